mem_arbiter: RTL and testbench

Sequencing controller that shares the single cache/memory port between the instruction-fetch requester and the load/store requester of the pipeline. Latches one request at a time, drives the cache read/write strobes, address and write data, waits for `cache_hit`, and returns a one-cycle acknowledge with read data to the granted requester. Data port has priority, with a starvation guard for fetch and a wait-limit timeout. Sits between the pipeline stages and the cache instance.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the cache/memory port arbiter.
package mem_pkg;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data, with a starvation counter that
// eventually forces a fetch grant when data keeps winning.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_idle,
  input  logic   i_if_req,
  input  logic   i_d_req,
  output owner_t o_win
);

  logic [3:0] r_starve;
  logic       w_starved;
  logic       w_if_win;

  // Data has priority unless fetch has lost STARVE_MAX arbitrations in a row
  always_comb begin
    w_starved = (r_starve == 4'(STARVE_MAX));
    w_if_win  = i_if_req && (!i_d_req || w_starved);
    o_win     = w_if_win ? OWN_IF : OWN_D;
  end

  // Count only lost contended arbitrations; any fetch grant or idle fetch clears
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (i_idle) begin
      if (!i_if_req || w_if_win)
        r_starve <= '0;
      else if (i_d_req && !w_starved)
        r_starve <= r_starve + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache port between fetch and load/store: latch one request,
// strobe the cache until hit or timeout, then ack the owner for one cycle.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int WAIT_MAX   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_op,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              cache_read,
  output logic              cache_write,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic [DATA_W-1:0] cache_rdata,
  input  logic              cache_hit,
  output logic              busy,
  output logic              timeout_err
);

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_win;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wait, w_wait_nxt;
  logic              r_if_ack, r_d_ack, r_tmo;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
  logic              w_latch, w_done, w_tmo;
  logic [DATA_W-1:0] w_cap;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_idle  (r_state == IDLE),
    .i_if_req(if_req),
    .i_d_req (d_req),
    .o_win   (w_win)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, wait counter and completion/timeout decisions
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    w_wait_nxt  = r_wait;
    case (r_state)
      IDLE: begin
        if (if_req || d_req) begin
          w_latch     = 1'b1;
          w_wait_nxt  = '0;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cache_hit) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
          if (w_wait_nxt == 8'(WAIT_MAX)) begin
            w_done      = 1'b1;
            w_tmo       = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Writes and timeouts return zero data
    w_cap = (w_tmo || r_write) ? '0 : cache_rdata;
  end

  // Request latch, response capture, one-cycle acks and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= OWN_IF;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait     <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_tmo      <= 1'b0;
    end else begin
      r_wait   <= w_wait_nxt;
      r_if_ack <= w_done && (r_owner == OWN_IF);
      r_d_ack  <= w_done && (r_owner == OWN_D);
      if (w_latch) begin
        r_owner <= w_win;
        r_addr  <= (w_win == OWN_IF) ? if_addr : d_addr;
        // Only the exact write code writes; every other op code reads
        r_write <= (w_win == OWN_D) && (d_op == OP_WRITE);
        if (w_win == OWN_D) r_wdata <= d_wdata;
      end
      if (w_done && (r_owner == OWN_IF)) r_if_rdata <= w_cap;
      if (w_done && (r_owner == OWN_D))  r_d_rdata  <= w_cap;
      if (w_tmo) r_tmo <= 1'b1;
    end
  end

  assign cache_read  = (r_state == ACCESS) && !r_write;
  assign cache_write = (r_state == ACCESS) && r_write;
  assign cache_addr  = r_addr;
  assign cache_wdata = r_wdata;
  assign if_ack      = r_if_ack;
  assign d_ack       = r_d_ack;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int WM = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic [1:0]    d_op = 2'b00;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          cache_read, cache_write;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_wdata;
  logic [DW-1:0] cache_rdata = '0;
  logic          cache_hit = 1'b0;
  logic          busy, timeout_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .WAIT_MAX(WM)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Model: phase 0 = waiting for requests, 1 = cache access, 2 = acknowledging
  int          m_ph, m_starve, m_wait;
  bit          m_own_if, m_wr, m_terr;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;

  function automatic void model_reset();
    m_ph = 0; m_starve = 0; m_wait = 0;
    m_own_if = 1'b0; m_wr = 1'b0; m_terr = 1'b0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
  endfunction

  function automatic void model_finish(input logic [31:0] data);
    if (m_own_if) m_if_rd = data;
    else          m_d_rd  = data;
    m_ph = 2;
  endfunction

  function automatic void model_step();
    if (!reset_n) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: begin
        if (if_req || d_req) begin
          m_own_if = if_req && (!d_req || m_starve == SM);
          if (!if_req || m_own_if) m_starve = 0;
          else m_starve = (m_starve < SM) ? m_starve + 1 : SM;
          m_addr = m_own_if ? if_addr : d_addr;
          if (!m_own_if) m_wdata = d_wdata;
          m_wr   = !m_own_if && (d_op == 2'b10);
          m_wait = 0;
          m_ph   = 1;
        end else begin
          m_starve = 0;
        end
      end
      1: begin
        if (cache_hit) begin
          model_finish(m_wr ? 32'h0 : cache_rdata);
        end else begin
          m_wait++;
          if (m_wait == WM) begin
            m_terr = 1'b1;
            model_finish(32'h0);
          end
        end
      end
      default: m_ph = 0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("busy",     32'(busy),        32'(m_ph != 0));
    chk("c_rd",     32'(cache_read),  32'(m_ph == 1 && !m_wr));
    chk("c_wr",     32'(cache_write), 32'(m_ph == 1 && m_wr));
    chk("c_addr",   cache_addr,       m_addr);
    if (m_ph == 1 && m_wr) chk("c_wdata", cache_wdata, m_wdata);
    chk("if_ack",   32'(if_ack),      32'(m_ph == 2 && m_own_if));
    chk("d_ack",    32'(d_ack),       32'(m_ph == 2 && !m_own_if));
    chk("if_rdata", if_rdata,         m_if_rd);
    chk("d_rdata",  d_rdata,          m_d_rd);
    chk("tmo",      32'(timeout_err), 32'(m_terr));
    chk("one_ack",  32'(if_ack & d_ack), 32'd0);
  endtask

  // Entered at a falling edge with inputs already driven; leaves at the next one
  task automatic cyc();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Run until an ack shows, hitting after miss_n strobe cycles
  task automatic run_ack(input int miss_n, output int lat, output int rd_n,
                         output int wr_n, output bit got_if, output bit got_d);
    int sc;
    sc = 0; lat = 0; rd_n = 0; wr_n = 0;
    while (!(if_ack || d_ack) && lat < 400) begin
      if (cache_read || cache_write) begin
        cache_hit = (sc >= miss_n);
        sc++;
      end else begin
        cache_hit = 1'b0;
      end
      rd_n += int'(cache_read);
      wr_n += int'(cache_write);
      cyc();
      lat++;
    end
    got_if = if_ack;
    got_d  = d_ack;
    if (!(if_ack || d_ack)) chk("ack_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rd_n, wr_n;
    bit gi, gd;
    int ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    model_reset();
    @(negedge clk);
    check_outputs();
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();

    // Single fetch, immediate hit
    if_req = 1'b1; if_addr = 32'h100; cache_rdata = 32'hDEADBEEF;
    run_ack(0, lat, rd_n, wr_n, gi, gd);
    chk("f_lat", lat, 32'd2);
    chk("f_who", 32'(gi), 32'd1);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_rd_cyc", rd_n, 32'd1);
    if_req = 1'b0;
    cyc();

    // d_op 00 and 11 both read
    d_req = 1'b1; d_op = 2'b00; d_addr = 32'h44; cache_rdata = 32'hA5A5;
    run_ack(0, lat, rd_n, wr_n, gi, gd);
    chk("op00_rd", rd_n, 32'd1);
    chk("op00_wr", wr_n, 32'd0);
    chk("op00_data", d_rdata, 32'hA5A5);
    d_op = 2'b11; d_addr = 32'h48; cache_rdata = 32'h5A5A;
    cyc();
    run_ack(1, lat, rd_n, wr_n, gi, gd);
    chk("op11_rd", rd_n, 32'd2);
    chk("op11_wr", wr_n, 32'd0);
    chk("op11_data", d_rdata, 32'h5A5A);
    d_req = 1'b0;
    cyc();

    // Write with three misses
    d_req = 1'b1; d_op = 2'b10; d_addr = 32'h40; d_wdata = 32'h1234;
    run_ack(3, lat, rd_n, wr_n, gi, gd);
    chk("w_who", 32'(gd), 32'd1);
    chk("w_cyc", wr_n, 32'd4);
    chk("w_lat", lat, 32'd5);
    chk("w_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    cyc();

    // Contention with both requesters held high
    cache_rdata = 32'hDEADBEEF;
    if_req = 1'b1; d_req = 1'b1; d_op = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if_addr = 32'h1000 + 32'(i); d_addr = 32'h2000 + 32'(i);
      run_ack(0, lat, rd_n, wr_n, gi, gd);
      chk("grant", 32'(gi), 32'(ord[i]));
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc();

    // Timeout, then sticky flag across a good access
    chk("tmo_pre", 32'(timeout_err), 32'd0);
    d_req = 1'b1; d_op = 2'b01; d_addr = 32'h80;
    run_ack(1000, lat, rd_n, wr_n, gi, gd);
    chk("t_lat", lat, 32'(WM + 1));
    chk("t_data", d_rdata, 32'd0);
    chk("t_flag", 32'(timeout_err), 32'd1);
    d_req = 1'b0;
    cyc();
    if_req = 1'b1; if_addr = 32'h200; cache_rdata = 32'h5555;
    run_ack(0, lat, rd_n, wr_n, gi, gd);
    chk("t_good", if_rdata, 32'h5555);
    chk("t_sticky", 32'(timeout_err), 32'd1);
    if_req = 1'b0;
    cyc();

    // Reset in the middle of a missing access
    d_req = 1'b1; d_op = 2'b01; d_addr = 32'h300; cache_hit = 1'b0; cache_rdata = 32'h77;
    cyc(); cyc(); cyc();
    reset_n = 1'b0;
    #1;
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_rd", 32'(cache_read), 32'd0);
    chk("r_addr", cache_addr, 32'd0);
    chk("r_ack", 32'(if_ack | d_ack), 32'd0);
    chk("r_tmo", 32'(timeout_err), 32'd0);
    chk("r_ifd", if_rdata, 32'd0);
    model_reset();
    cyc(); cyc();
    reset_n = 1'b1;
    run_ack(0, lat, rd_n, wr_n, gi, gd);
    chk("r_lat", lat, 32'd2);
    chk("r_who", 32'(gd), 32'd1);
    chk("r_data", d_rdata, 32'h77);
    d_req = 1'b0;
    cyc();

    // Random traffic; agents only change a held request in its ack cycle
    for (int c = 0; c < 2000; c++) begin
      bit ifa, da;
      ifa = (m_ph == 2) && m_own_if;
      da  = (m_ph == 2) && !m_own_if;
      if (!if_req || ifa) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom;
      end
      if (!d_req || da) begin
        d_req   = ($urandom_range(0, 1) != 0);
        d_op    = 2'($urandom_range(0, 3));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      cache_hit   = ((c % 300) < 12) ? 1'b0 : ($urandom_range(0, 9) < 7);
      cache_rdata = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
